// File: rtl/controller_pkg.sv
// Shared encodings for the multicycle controller: FSM states, ALU operations,
// datapath select codes and condition codes.
package controller_pkg;

   localparam int unsigned AlucW  = 4;
   localparam int unsigned StateW = 4;

   typedef enum logic [3:0] {
      StFetch    = 4'd0,
      StDecode   = 4'd1,
      StMemAdr   = 4'd2,
      StMemRead  = 4'd3,
      StMemWb    = 4'd4,
      StMemWrite = 4'd5,
      StExecR    = 4'd6,
      StExecI    = 4'd7,
      StAluWb    = 4'd8,
      StBranch   = 4'd9
   } state_e;

   localparam logic [3:0] AluAdd = 4'b0100;
   localparam logic [3:0] AluSub = 4'b0010;

   localparam logic [1:0] SrcBReg  = 2'd0;
   localparam logic [1:0] SrcBImm  = 2'd1;
   localparam logic [1:0] SrcBFour = 2'd2;
   localparam logic [1:0] SrcBZero = 2'd3;

   localparam logic [1:0] ResAluOut    = 2'd0;
   localparam logic [1:0] ResReadData  = 2'd1;
   localparam logic [1:0] ResAluResult = 2'd2;

   localparam logic [3:0] CondEq = 4'b0000;
   localparam logic [3:0] CondNe = 4'b0001;
   localparam logic [3:0] CondAl = 4'b1110;

endpackage

// File: rtl/cond_check.sv
// Condition-field evaluation against the architectural Z flag.
// Only EQ, NE and AL are supported; every other code fails.
module cond_check
   import controller_pkg::*;
(
   input  logic [3:0] cond_i,
   input  logic       z_i,
   output logic       pass_o
);

   always_comb begin
      pass_o = 1'b0;
      case (cond_i)
         CondEq:  pass_o = z_i;
         CondNe:  pass_o = ~z_i;
         CondAl:  pass_o = 1'b1;
         default: pass_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM for the multicycle ARM-subset datapath; also owns the
// architectural Z flag since the datapath re-registers Z every cycle.
module multicycle_controller
   import controller_pkg::*;
#(
   parameter int unsigned ALUC_W  = AlucW,
   parameter int unsigned STATE_W = StateW
) (
   input  logic               CLK,
   input  logic               RESET,
   input  logic [31:0]        INSTR,
   input  logic               FlagZ,
   output logic               RegWrite,
   output logic               MemWrite,
   output logic               IRWrite,
   output logic               PCWrite,
   output logic               AdSrc,
   output logic               ALUSrcA,
   output logic               Sel14,
   output logic [1:0]         RegSrc,
   output logic [1:0]         ImmSrc,
   output logic [1:0]         ALUSrcB,
   output logic [1:0]         ResultSrc,
   output logic [ALUC_W-1:0]  ALUControl,
   output logic               CondZ,
   output logic [STATE_W-1:0] State
);

   state_e     state_q, state_d;
   logic       condz_q, condz_d;
   logic       cond_pass;
   logic       reg_write, mem_write, ir_write, pc_write;
   logic [3:0] alu_ctrl;
   logic [1:0] op;
   logic       rd_is_pc;
   logic       unused_instr;

   assign op           = INSTR[27:26];
   assign rd_is_pc     = (INSTR[15:12] == 4'hF);
   assign unused_instr = ^{INSTR[19:16], INSTR[11:0]};

   cond_check u_cond_check (
      .cond_i (INSTR[31:28]),
      .z_i    (condz_q),
      .pass_o (cond_pass)
   );

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q <= StFetch;
         condz_q <= 1'b0;
      end else begin
         state_q <= state_d;
         condz_q <= condz_d;
      end
   end

   always_comb begin
      state_d   = StFetch;
      condz_d   = condz_q;
      reg_write = 1'b0;
      mem_write = 1'b0;
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      AdSrc     = 1'b0;
      ALUSrcA   = 1'b0;
      Sel14     = 1'b0;
      RegSrc    = 2'b00;
      ImmSrc    = 2'b00;
      ALUSrcB   = SrcBReg;
      ResultSrc = ResAluOut;
      alu_ctrl  = 4'b0000;
      case (state_q)
         StFetch: begin
            ir_write  = 1'b1;
            pc_write  = 1'b1;
            ALUSrcA   = 1'b1;
            ALUSrcB   = SrcBFour;
            alu_ctrl  = AluAdd;
            ResultSrc = ResAluResult;
            state_d   = StDecode;
         end
         StDecode: begin
            // PC+4 again so that R15 reads as instruction address + 8
            ALUSrcA   = 1'b1;
            ALUSrcB   = SrcBFour;
            alu_ctrl  = AluAdd;
            ResultSrc = ResAluResult;
            RegSrc    = {op == 2'b01, op == 2'b10};
            ImmSrc    = op;
            if (!cond_pass) begin
               state_d = StFetch;
            end else begin
               case (op)
                  2'b00:   state_d = INSTR[25] ? StExecI : StExecR;
                  2'b01:   state_d = StMemAdr;
                  2'b10:   state_d = StBranch;
                  default: state_d = StFetch;
               endcase
            end
         end
         StMemAdr: begin
            ALUSrcB  = SrcBImm;
            ImmSrc   = 2'b01;
            alu_ctrl = INSTR[23] ? AluAdd : AluSub;
            state_d  = INSTR[20] ? StMemRead : StMemWrite;
         end
         StMemRead: begin
            AdSrc   = 1'b1;
            state_d = StMemWb;
         end
         StMemWb: begin
            ResultSrc = ResReadData;
            reg_write = 1'b1;
            pc_write  = rd_is_pc;
         end
         StMemWrite: begin
            AdSrc     = 1'b1;
            RegSrc    = 2'b10;
            mem_write = 1'b1;
         end
         StExecR, StExecI: begin
            ALUSrcB  = (state_q == StExecI) ? SrcBImm : SrcBReg;
            alu_ctrl = INSTR[24:21];
            state_d  = StAluWb;
         end
         StAluWb: begin
            // TST/TEQ/CMP/CMN only set flags
            reg_write = (INSTR[24:23] != 2'b10);
            pc_write  = reg_write & rd_is_pc;
            if (INSTR[20]) condz_d = FlagZ;
         end
         StBranch: begin
            RegSrc    = 2'b01;
            ALUSrcB   = SrcBImm;
            ImmSrc    = 2'b10;
            alu_ctrl  = AluAdd;
            ResultSrc = ResAluResult;
            pc_write  = 1'b1;
            Sel14     = INSTR[24];
            reg_write = INSTR[24];
         end
         default: state_d = StFetch;
      endcase
   end

   // Write enables must stay low for as long as reset is held.
   assign RegWrite   = reg_write & RESET;
   assign MemWrite   = mem_write & RESET;
   assign IRWrite    = ir_write & RESET;
   assign PCWrite    = pc_write & RESET;
   assign ALUControl = ALUC_W'(alu_ctrl);
   assign CondZ      = condz_q;
   assign State      = STATE_W'(state_q);

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Control unit for the multicycle ARM-subset datapath, directly upstream of it. Consumes the latched instruction and the registered Z flag, and drives every datapath control strobe and select. A Moore FSM sequences FETCH/DECODE/execute states, one cycle per state. It also holds the architectural Z flag, because the datapath re-registers Z every cycle.

Parameters:
ALUC_W, 4, width of ALUControl
STATE_W, 4, width of the state encoding and of the debug state output

Ports:
CLK  input  1  clock, rising edge
RESET  input  1  asynchronous, active-low reset
INSTR  input  32  instruction register contents
FlagZ  input  1  Z of the previous cycle's ALUResult
RegWrite  output  1  register file write enable
MemWrite  output  1  memory write enable
IRWrite  output  1  instruction register load
PCWrite  output  1  PC load from Result
AdSrc  output  1  memory address: 0=PC, 1=Result
ALUSrcA  output  1  0=RD1 latch, 1=PC
Sel14  output  1  write R14 with PC (BL link)
RegSrc  output  2  [0]: RA1=R15; [1]: RA2=Rd
ImmSrc  output  2  extender mode, equal to INSTR[27:26]
ALUSrcB  output  2  0=shifted RD2, 1=ExtImm, 2=constant 4, 3=zero
ResultSrc  output  2  0=ALUOut, 1=ReadData latch, 2=ALUResult
ALUControl  output  4  ALU operation; ARM cmd encoding, ADD=0100, SUB=0010
CondZ  output  1  architectural Z flag
State  output  4  current state, for debug

Behaviour:
- Reset (RESET=0): state=FETCH and CondZ=0, asynchronously. All write enables (RegWrite, MemWrite, IRWrite, PCWrite) are forced 0 while reset is held. First fetch occurs on the first edge after release.
- Outputs are a pure function of state, INSTR and CondZ. Unlisted outputs are 0.
- FETCH: AdSrc=0, IRWrite=1, ALUSrcA=1, ALUSrcB=2, ADD, ResultSrc=2, PCWrite=1. Next state: DECODE.
- DECODE: ALUSrcA=1, ALUSrcB=2, ADD, ResultSrc=2 (R15 reads PC+8). RegSrc={op==01, op==10}. ImmSrc=INSTR[27:26].
  - Condition fail -> FETCH.
  - op=01 -> MEMADR.
  - op=00 with I=0 -> EXECR; op=00 with I=1 -> EXECI.
  - op=10 -> BRANCH.
  - op=11 -> FETCH (no-op).
- Condition check on INSTR[31:28]:
  - EQ (0000) passes when CondZ=1.
  - NE (0001) passes when CondZ=0.
  - AL (1110) always passes.
  - All other codes fail, executing as a no-op.
- MEMADR: ALUSrcA=0, ALUSrcB=1, ImmSrc=01. ADD if INSTR[23]=1, else SUB. Next: MEMREAD if L (INSTR[20])=1, else MEMWRITE.
- MEMREAD: AdSrc=1, ResultSrc=0. Next: MEMWB.
- MEMWB: ResultSrc=1, RegWrite=1. If Rd=15, also PCWrite=1. Next: FETCH.
- MEMWRITE: AdSrc=1, ResultSrc=0, RegSrc[1]=1, MemWrite=1. Next: FETCH.
- EXECR / EXECI: ALUSrcA=0, ALUSrcB=0 (EXECR) or 1 (EXECI), ImmSrc=00, ALUControl=INSTR[24:21]. Next: ALUWB.
- ALUWB: ResultSrc=0.
  - RegWrite=1 unless cmd=10xx (TST/TEQ/CMP/CMN).
  - PCWrite=1 when RegWrite=1 and Rd=15.
  - If S (INSTR[20])=1: CondZ<=FlagZ on the edge leaving ALUWB. Otherwise CondZ is held.
  - Next: FETCH.
- BRANCH: RegSrc[0]=1, ALUSrcA=0, ALUSrcB=1, ImmSrc=10, ADD, ResultSrc=2, PCWrite=1.
  - If L (INSTR[24])=1: Sel14=1 and RegWrite=1, so R14 receives the not-yet-updated PC (= instr+4).
  - Next: FETCH.
- Latencies in cycles:
  - Condition-fail and op=11: 2.
  - Branch: 3.
  - Data processing: 4.
  - STR: 4.
  - LDR: 5.
- Illegal state encodings recover to FETCH on the next edge.
- Reset asserted mid-instruction aborts it. No write enable is asserted from the reset edge onward.

Decomposition:
- Package controller_pkg holds:
  - State encodings: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH.
  - ALUControl constants.
  - ALUSrcB and ResultSrc select codes.
  - Condition codes EQ/NE/AL.
- One sub-module, cond_check: combinational (cond[3:0], Z) -> pass.

Test Plan:
- Reset: hold RESET=0 for 3 cycles, release -> State=FETCH, all enables 0 during reset, IRWrite=PCWrite=1 on the first cycle after release.
- ADD R1,R2,#5 (0xE2821005) -> states FETCH,DECODE,EXECI,ALUWB; ALUControl=0100 and ALUSrcB=1 in EXECI; RegWrite=1 only in ALUWB.
- LDR R0,[R1,#4] (0xE5910004) -> 5 cycles ending MEMWB with ResultSrc=1 and RegWrite=1. STR (0xE5810004) -> MemWrite=1 and AdSrc=1 for exactly one cycle.
- CMP R1,R1 (0xE1510001) with FlagZ=1 in ALUWB -> RegWrite=0, CondZ=1 afterwards. Then BEQ (0x0A000002) -> BRANCH with PCWrite=1.
- CondZ=0, BEQ (0x0A000002) -> FETCH,DECODE,FETCH, with no PCWrite in DECODE.
- BL (0xEB000002) -> BRANCH with Sel14=1, RegWrite=1, PCWrite=1, ImmSrc=10.
